// File: rtl/coll_pkg.sv
`default_nettype none
// ============================================================================
// Module : coll_pkg
// Types and default sizes shared by the collision pair scheduler.
// Rev    : 1.0
// ============================================================================
package coll_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 31;
  localparam int OBJ_W       = 4 * DEF_DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] x;
    logic [DEF_DATA_W-1:0] y;
    logic [DEF_DATA_W-1:0] vx;
    logic [DEF_DATA_W-1:0] vy;
  } obj_state_t;

endpackage
`default_nettype wire

// File: rtl/coll_obj_table.sv
`default_nettype none
// ============================================================================
// Module : coll_obj_table
// Object state register file: one write port, two combinational read ports.
// Rev    : 1.0
// ============================================================================
module coll_obj_table
  import coll_pkg::*;
#(
  parameter int N_OBJ = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OBJ_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_i_idx_i,
  input  logic [IDX_W-1:0] rd_j_idx_i,
  output logic [OBJ_W-1:0] rd_i_o,
  output logic [OBJ_W-1:0] rd_j_o
);

  obj_state_t mem_q [N_OBJ];

  // Indices at or beyond N_OBJ match no entry, so such writes fall away.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_OBJ; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      for (int k = 0; k < N_OBJ; k++) begin
        if (wr_idx_i == IDX_W'(k)) mem_q[k] <= obj_state_t'(wr_data_i);
      end
    end
  end

  always_comb begin
    rd_i_o = '0;
    rd_j_o = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (rd_i_idx_i == IDX_W'(k)) rd_i_o = mem_q[k];
      if (rd_j_idx_i == IDX_W'(k)) rd_j_o = mem_q[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/coll_pair_sched.sv
`default_nettype none
// ============================================================================
// Module : coll_pair_sched
// Walks every unordered object pair (i<j) through the collision detector.
// Rev    : 1.0
// ============================================================================
module coll_pair_sched
  import coll_pkg::*;
#(
  parameter int N_OBJ   = 8,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = DEF_DATA_W,  // table storage is obj_state_t, keep equal to DEF_DATA_W
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_x_i,
  input  logic [DATA_W-1:0] wr_y_i,
  input  logic [DATA_W-1:0] wr_vx_i,
  input  logic [DATA_W-1:0] wr_vy_i,
  input  logic [DATA_W-1:0] r2_cfg_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              hit_valid_o,
  output logic [IDX_W-1:0]  hit_i_o,
  output logic [IDX_W-1:0]  hit_j_o,
  output logic [7:0]        hit_cnt_o,
  output logic [DATA_W-1:0] x1_o,
  output logic [DATA_W-1:0] y1_o,
  output logic [DATA_W-1:0] vx1_o,
  output logic [DATA_W-1:0] vy1_o,
  output logic [DATA_W-1:0] x2_o,
  output logic [DATA_W-1:0] y2_o,
  output logic [DATA_W-1:0] vx2_o,
  output logic [DATA_W-1:0] vy2_o,
  output logic [DATA_W-1:0] r2_o,
  output logic              in_rdy_o,
  input  logic              trial_i,
  input  logic              out_rdy_i
);

  localparam int               TMO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_J  = IDX_W'(N_OBJ - 1);
  localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(N_OBJ - 2);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  i_q, j_q, hit_i_q, hit_j_q;
  logic [DATA_W-1:0] r2_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              err_q, hit_valid_q;
  logic [7:0]        hit_cnt_q;
  obj_state_t        opi_q, opj_q;
  logic [OBJ_W-1:0]  rd_i, rd_j;
  logic              more_pairs;

  coll_obj_table #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) u_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (wr_en_i && (state_q == S_IDLE)),
    .wr_idx_i   (wr_idx_i),
    .wr_data_i  ({wr_x_i, wr_y_i, wr_vx_i, wr_vy_i}),
    .rd_i_idx_i (i_q),
    .rd_j_idx_i (j_q),
    .rd_i_o     (rd_i),
    .rd_j_o     (rd_j)
  );

  assign more_pairs = (j_q < LAST_J) || (i_q < LAST_I);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (out_rdy_i)              state_d = S_NEXT;
        else if (tmo_q == TMO_MAX)  state_d = S_FIN;
      end
      S_NEXT:  state_d = more_pairs ? S_ISSUE : S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // in_rdy is a decode of the state register, so it is high exactly in WAIT.
  always_comb begin
    busy_o   = 1'b0;
    done_o   = 1'b0;
    in_rdy_o = 1'b0;
    case (state_q)
      S_ISSUE, S_NEXT: busy_o = 1'b1;
      S_WAIT: begin
        busy_o   = 1'b1;
        in_rdy_o = 1'b1;
      end
      S_FIN:   done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_q         <= '0;
      j_q         <= '0;
      r2_q        <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_i_q     <= '0;
      hit_j_q     <= '0;
      hit_cnt_q   <= '0;
      opi_q       <= '0;
      opj_q       <= '0;
    end else begin
      hit_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          i_q       <= '0;
          j_q       <= IDX_W'(1);
          r2_q      <= r2_cfg_i;
          hit_cnt_q <= '0;
          err_q     <= 1'b0;
        end
        S_ISSUE: begin
          opi_q <= obj_state_t'(rd_i);
          opj_q <= obj_state_t'(rd_j);
          tmo_q <= '0;
        end
        S_WAIT: begin
          if (out_rdy_i) begin
            if (trial_i) begin
              hit_valid_q <= 1'b1;
              hit_i_q     <= i_q;
              hit_j_q     <= j_q;
              if (hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
            end
          end else if (tmo_q == TMO_MAX) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_NEXT: begin
          if (j_q < LAST_J) begin
            j_q <= j_q + IDX_W'(1);
          end else if (i_q < LAST_I) begin
            i_q <= i_q + IDX_W'(1);
            j_q <= i_q + IDX_W'(2);
          end
        end
        default: ;
      endcase
    end
  end

  assign err_o       = err_q;
  assign hit_valid_o = hit_valid_q;
  assign hit_i_o     = hit_i_q;
  assign hit_j_o     = hit_j_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign x1_o        = opi_q.x;
  assign y1_o        = opi_q.y;
  assign vx1_o       = opi_q.vx;
  assign vy1_o       = opi_q.vy;
  assign x2_o        = opj_q.x;
  assign y2_o        = opj_q.y;
  assign vx2_o       = opj_q.vx;
  assign vy2_o       = opj_q.vy;
  assign r2_o        = r2_q;

endmodule
`default_nettype wire

// File: tb/tb_coll_pair_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_coll_pair_sched
// Directed bench: a 3-object and an 8-object scheduler with detector models.
// Rev    : 1.0
// ============================================================================
module tb_coll_pair_sched;

  typedef struct packed {
    logic [31:0] x1, y1, vx1, vy1, x2, y2, vx2, vy2, r2;
  } req_t;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] x, y, vx, vy;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [3:0]  wr_idx = '0;
  logic [31:0] wr_x = '0, wr_y = '0, wr_vx = '0, wr_vy = '0, r2_cfg = '0;

  logic        wr_en_a = 0, start_a = 0, busy_a, done_a, err_a, hv_a, in_rdy_a, trial_a, out_rdy_a;
  logic [3:0]  hi_a, hj_a;
  logic [7:0]  hc_a;
  logic [31:0] a_x1, a_y1, a_vx1, a_vy1, a_x2, a_y2, a_vx2, a_vy2, a_r2;

  logic        wr_en_b = 0, start_b = 0, busy_b, done_b, err_b, hv_b, in_rdy_b;
  logic        trial_b = 0, out_rdy_b = 0;
  logic [3:0]  hi_b, hj_b;
  logic [7:0]  hc_b;
  logic [31:0] b_x1, b_y1, b_vx1, b_vy1, b_x2, b_y2, b_vx2, b_vy2, b_r2;

  coll_pair_sched #(.N_OBJ(3), .IDX_W(4), .DATA_W(32), .TIMEOUT(31)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en_a), .wr_idx_i(wr_idx),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_vx_i(wr_vx), .wr_vy_i(wr_vy),
    .r2_cfg_i(r2_cfg), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .hit_valid_o(hv_a), .hit_i_o(hi_a), .hit_j_o(hj_a), .hit_cnt_o(hc_a),
    .x1_o(a_x1), .y1_o(a_y1), .vx1_o(a_vx1), .vy1_o(a_vy1),
    .x2_o(a_x2), .y2_o(a_y2), .vx2_o(a_vx2), .vy2_o(a_vy2), .r2_o(a_r2),
    .in_rdy_o(in_rdy_a), .trial_i(trial_a), .out_rdy_i(out_rdy_a)
  );

  coll_pair_sched #(.N_OBJ(8), .IDX_W(4), .DATA_W(32), .TIMEOUT(31)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en_b), .wr_idx_i(wr_idx),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_vx_i(wr_vx), .wr_vy_i(wr_vy),
    .r2_cfg_i(r2_cfg), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .hit_valid_o(hv_b), .hit_i_o(hi_b), .hit_j_o(hj_b), .hit_cnt_o(hc_b),
    .x1_o(b_x1), .y1_o(b_y1), .vx1_o(b_vx1), .vy1_o(b_vy1),
    .x2_o(b_x2), .y2_o(b_y2), .vx2_o(b_vx2), .vy2_o(b_vy2), .r2_o(b_r2),
    .in_rdy_o(in_rdy_b), .trial_i(trial_b), .out_rdy_i(out_rdy_b)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Detector model for the 3-object instance; hits only pair (0,1) (x1=0, x2=10).
  logic det_en = 1'b1, det_never = 1'b0, m_rdy_a = 1'b0, m_trial_a = 1'b0;
  logic man_rdy_a = 1'b0, man_trial_a = 1'b0;
  int   det_dly = 10, det_cnt = 0;
  assign out_rdy_a = det_en ? m_rdy_a : man_rdy_a;
  assign trial_a   = det_en ? m_trial_a : man_trial_a;

  always @(negedge clk) begin
    if (det_en) begin
      if (!in_rdy_a) begin
        m_rdy_a = 1'b0; m_trial_a = 1'b0; det_cnt = 0;
      end else if (!m_rdy_a && !det_never) begin
        det_cnt++;
        if (det_cnt >= det_dly) begin
          m_rdy_a   = 1'b1;
          m_trial_a = (a_x1 == 32'd0) && (a_x2 == 32'd10);
        end
      end
    end
  end

  req_t       ops_a, rise_a;
  req_t       req_a[$];
  logic [7:0] hits_a[$];
  int         done_cnt_a = 0, unstable_a = 0, run_a = 0, last_run_a = 0, low_a = 0, min_low_a = 1000;
  logic       prev_a = 1'b0;
  assign ops_a = {a_x1, a_y1, a_vx1, a_vy1, a_x2, a_y2, a_vx2, a_vy2, a_r2};

  always @(negedge clk) begin
    if (in_rdy_a) begin
      if (!prev_a) begin
        req_a.push_back(ops_a);
        rise_a = ops_a;
        run_a  = 0;
        if (low_a < min_low_a) min_low_a = low_a;
        low_a = 0;
      end else if (ops_a !== rise_a) begin
        unstable_a++;
      end
      run_a++;
    end else begin
      if (prev_a) last_run_a = run_a;
      low_a++;
    end
    if (hv_a) hits_a.push_back({hi_a, hj_a});
    if (done_a) done_cnt_a++;
    prev_a = in_rdy_a;
  end

  // 8-object instance: detector answers one cycle after in_rdy, always colliding.
  logic [7:0]  hits_b[$];
  int          done_cnt_b = 0, req_cnt_b = 0;
  logic        prev_b = 1'b0;
  logic [31:0] last_x2_b = '0;

  always @(negedge clk) begin
    if (!in_rdy_b) begin
      out_rdy_b = 1'b0; trial_b = 1'b0;
    end else if (!out_rdy_b) begin
      out_rdy_b = 1'b1; trial_b = 1'b1;
    end
    if (in_rdy_b && !prev_b) begin
      req_cnt_b++;
      last_x2_b = b_x2;
    end
    if (hv_b) hits_b.push_back({hi_b, hj_b});
    if (done_b) done_cnt_b++;
    prev_b = in_rdy_b;
  end

  task automatic wr_obj(input wr_t w);
    wr_idx = w.idx; wr_x = w.x; wr_y = w.y; wr_vx = w.vx; wr_vy = w.vy;
    wr_en_a = 1'b1;
    @(posedge clk); #1;
    wr_en_a = 1'b0;
  endtask

  task automatic go_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1'b1);
  endtask

  task automatic wait_done_a(input int lim);
    int d0 = done_cnt_a;
    int k  = 0;
    while (done_cnt_a == d0 && k < lim) begin
      @(posedge clk); k++;
    end
    #1;
    chk("a_done_pulse", done_cnt_a - d0, 1);
  endtask

  task automatic clear_logs();
    req_a.delete(); hits_a.delete();
    unstable_a = 0; min_low_a = 1000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t        wv[3];
    req_t       ex[3];
    logic [7:0] exb[$];
    int         d0, nh, k;

    wv[0] = '{4'd0, 32'd0,   32'd0,   32'd1,         32'd0};
    wv[1] = '{4'd1, 32'd10,  32'd0,   32'hFFFF_FFFF, 32'd0};
    wv[2] = '{4'd2, 32'd100, 32'd100, 32'd0,         32'd0};
    ex[0] = {32'd0,  32'd0, 32'd1,         32'd0, 32'd10,  32'd0,   32'hFFFF_FFFF, 32'd0, 32'd25};
    ex[1] = {32'd0,  32'd0, 32'd1,         32'd0, 32'd100, 32'd100, 32'd0,         32'd0, 32'd25};
    ex[2] = {32'd10, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd100, 32'd100, 32'd0,         32'd0, 32'd25};
    for (int i = 0; i < 7; i++)
      for (int j = i + 1; j < 8; j++) exb.push_back({i[3:0], j[3:0]});

    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_hit_valid", hv_a, 1'b0);
    chk("rst_hit_cnt", hc_a, 8'd0);
    chk("rst_in_rdy", in_rdy_a, 1'b0);
    chk("rst_operands", ops_a, '0);
    chk("rst_hit_idx", {hi_a, hj_a}, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal sweep, 10-cycle detector latency.
    for (int w = 0; w < 3; w++) wr_obj(wv[w]);
    r2_cfg = 32'd25; det_dly = 10;
    clear_logs();
    go_a();
    wait_done_a(400);
    chk("s1_req_count", req_a.size(), 3);
    for (int r = 0; r < 3; r++) chk($sformatf("s1_req%0d", r), req_a[r], ex[r]);
    chk("s1_hit_count", hits_a.size(), 1);
    chk("s1_hit_pair", hits_a[0], 8'h01);
    chk("s1_hit_cnt", hc_a, 8'd1);
    chk("s1_err", err_a, 1'b0);
    chk("s1_busy_end", busy_a, 1'b0);
    chk("s1_stable", unstable_a, 0);

    // Fast detector: check the gap between pairs and operand stability.
    det_dly = 1;
    clear_logs();
    go_a();
    wait_done_a(400);
    chk("s2_req_count", req_a.size(), 3);
    chk("s2_gap_ge1", min_low_a >= 1, 1'b1);
    chk("s2_stable", unstable_a, 0);
    chk("s2_hit_cnt", hc_a, 8'd1);
    chk("s2_hit_pair", hits_a[0], 8'h01);

    // Detector never answers: abort after 32 cycles of in_rdy.
    det_never = 1'b1;
    clear_logs();
    go_a();
    wait_done_a(200);
    chk("to_in_rdy_len", last_run_a, 32);
    chk("to_err", err_a, 1'b1);
    chk("to_busy", busy_a, 1'b0);
    chk("to_req_count", req_a.size(), 1);
    det_never = 1'b0;
    go_a();
    chk("to_err_cleared", err_a, 1'b0);
    wait_done_a(400);
    chk("to_err_after", err_a, 1'b0);

    // Write and restart attempts while busy are ignored.
    det_dly = 10;
    clear_logs();
    go_a();
    repeat (5) @(posedge clk);
    #1;
    wr_idx = 4'd2; wr_x = 32'h55; wr_y = 32'h55; wr_vx = 32'h55; wr_vy = 32'h55;
    wr_en_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    wr_en_a = 1'b0; start_a = 1'b0;
    wait_done_a(400);
    d0 = done_cnt_a;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_req_count", req_a.size(), 3);
    chk("mid_no_restart", done_cnt_a - d0, 0);
    chk("mid_req1", req_a[1], ex[1]);
    chk("mid_req2", req_a[2], ex[2]);
    chk("mid_busy", busy_a, 1'b0);

    // Asynchronous reset while waiting on pair (1,2).
    clear_logs();
    go_a();
    k = 0;
    while (req_a.size() < 3 && k < 300) begin
      @(posedge clk); k++;
    end
    chk("rr_reached_pair12", req_a.size(), 3);
    @(negedge clk);
    @(negedge clk);
    #2;
    det_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rr_in_rdy", in_rdy_a, 1'b0);
    chk("rr_busy", busy_a, 1'b0);
    chk("rr_operands", ops_a, '0);
    chk("rr_hit_cnt", hc_a, 8'd0);
    nh = hits_a.size();
    d0 = done_cnt_a;
    @(negedge clk) rst_n = 1'b1;
    man_rdy_a = 1'b1; man_trial_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    man_rdy_a = 1'b0; man_trial_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_no_hit", hits_a.size(), nh);
    chk("rr_no_done", done_cnt_a - d0, 0);
    chk("rr_idle", busy_a, 1'b0);
    det_en = 1'b1;

    // 8 objects, every pair collides; write of entry 7 lands with start.
    @(posedge clk); #1;
    wr_idx = 4'd7; wr_x = 32'h77; wr_y = '0; wr_vx = '0; wr_vy = '0;
    wr_en_b = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    wr_en_b = 1'b0; start_b = 1'b0;
    chk("b_busy_after_start", busy_b, 1'b1);
    k = 0;
    while (done_cnt_b == 0 && k < 600) begin
      @(posedge clk); k++;
    end
    #1;
    chk("b_done_pulse", done_cnt_b, 1);
    chk("b_req_count", req_cnt_b, 28);
    chk("b_hit_count", hits_b.size(), 28);
    for (int h = 0; h < 28; h++) chk($sformatf("b_hit%0d", h), hits_b[h], exb[h]);
    chk("b_hit_cnt", hc_b, 8'd28);
    chk("b_last_x2", last_x2_b, 32'h77);
    chk("b_err", err_b, 1'b0);
    chk("b_busy_end", busy_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coll_pair_sched.md
Name: coll_pair_sched

Overview:
Initiator for the collision-detector datapath. It holds a small table of object states (position and velocity) and, on `start`, walks every unordered pair (i<j). For each pair it drives x1..vy2 and r2 into the detector, holds `in_rdy` high, and waits for `out_rdy`. Each positive `trial` is reported as a hit event, and a summary is produced when the sweep completes. It sits between the physics-step controller (host side) and the detector instance.

Parameters:
N_OBJ, 8, number of table entries (2..16)
IDX_W, 4, index width; must satisfy 2^IDX_W >= N_OBJ
DATA_W, 32, width of coordinate, velocity and r2 words
TIMEOUT, 31, maximum cycles to wait for `out_rdy` per pair before aborting

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe (honoured only in IDLE)
wr_idx  in  IDX_W  table entry to write
wr_x, wr_y, wr_vx, wr_vy  in  DATA_W each  object state to write
r2_cfg  in  DATA_W  squared collision radius, latched at start
start  in  1  one-cycle sweep request
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the sweep ends (normal or abort)
err  out  1  sticky timeout flag; cleared by the next accepted start
hit_valid  out  1  one-cycle pulse, one per colliding pair
hit_i, hit_j  out  IDX_W each  pair indices for the hit, hit_i < hit_j
hit_cnt  out  8  number of hits in the current/last sweep; saturates at 255
x1, y1, vx1, vy1  out  DATA_W each  detector operands for object i
x2, y2, vx2, vy2  out  DATA_W each  detector operands for object j
r2  out  DATA_W  detector radius operand
in_rdy  out  1  detector request
trial  in  1  detector result; valid when out_rdy is high
out_rdy  in  1  detector result strobe

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM returns to IDLE.
  - All outputs are 0: in_rdy, busy, done, err, hit_valid, hit_cnt, hit_i, hit_j, all operand buses.
  - Table contents are cleared to 0.
  - A reset during WAIT drops in_rdy immediately. Any later out_rdy is ignored because the FSM is in IDLE.
- States: IDLE, ISSUE, WAIT, NEXT, FIN.
- IDLE:
  - wr_en writes the table entry in the same cycle. If wr_idx >= N_OBJ the write is ignored.
  - start=1 sets i=0, j=1, latches r2_cfg, clears hit_cnt and err, sets busy=1, and goes to ISSUE.
  - wr_en and start in the same cycle: the write lands first, and the sweep uses the new data.
- ISSUE (1 cycle):
  - Operand registers load table[i] and table[j]; r2 is driven from the latched value.
  - in_rdy is registered to 1. The timeout counter clears. Go to WAIT.
  - Operands and in_rdy become visible on the cycle after ISSUE and stay stable throughout WAIT.
- WAIT:
  - If out_rdy=1: capture trial and drop in_rdy to 0 on the next edge.
    - If trial=1: hit_valid=1 next cycle with hit_i=i, hit_j=j, and hit_cnt increments (saturating).
    - Go to NEXT.
  - Else, if the timeout counter == TIMEOUT: set err=1, drop in_rdy, go to FIN.
  - Else: increment the timeout counter.
- NEXT (1 cycle), index advance:
  - If j < N_OBJ-1: j=j+1, go to ISSUE.
  - Else if i < N_OBJ-2: i=i+1, j=i+2, go to ISSUE.
  - Else go to FIN.
  - in_rdy stays 0 for at least one cycle between pairs.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Total pairs per sweep are N_OBJ*(N_OBJ-1)/2 (28 at the default).
- Ignored requests:
  - start asserted while busy is ignored.
  - wr_en asserted while busy is ignored; the table is locked during a sweep.
- No backpressure on hit events; the consumer must accept every hit_valid pulse.
- Indices and operands are passed through unsigned and unmodified. This block does no arithmetic on them.

Decomposition:
- Package `coll_pkg` contains:
  - the FSM state enum `sched_state_t`;
  - the `obj_state_t` struct {x, y, vx, vy}, each DATA_W wide;
  - the default DATA_W and TIMEOUT constants.
- One sub-module, `coll_obj_table`:
  - N_OBJ x obj_state_t register file;
  - one write port and two combinational read ports (i, j);
  - asynchronous active-low clear.

Test Plan:
- N_OBJ=3; write obj0=(0,0,1,0), obj1=(10,0,-1,0), obj2=(100,100,0,0); r2_cfg=25; the detector model returns trial=1 only for pair (0,1) after 10 cycles.
  - Required: exactly 3 requests in order (0,1), (0,2), (1,2).
  - One hit_valid with hit_i=0, hit_j=1; hit_cnt=1.
  - done pulses once, err=0.
- The detector model responds with out_rdy 1 cycle after in_rdy.
  - Required: in_rdy goes low for at least 1 cycle between pairs.
  - Operands are stable from in_rdy rising until out_rdy.
- The detector never asserts out_rdy; TIMEOUT=31.
  - Required: in_rdy held for 32 cycles, then dropped.
  - err=1, done pulses, busy=0; err clears on the next start.
- wr_en with wr_idx=2 and data 0x55 mid-sweep, plus a second start mid-sweep.
  - Required: the table entry is unchanged and the sweep is not restarted.
- reset_n pulsed low during WAIT on pair (1,2).
  - Required: in_rdy, busy and operand buses go to 0 asynchronously.
  - A subsequent out_rdy produces no hit_valid or done.
- N_OBJ=8, all pairs colliding.
  - Required: 28 hit_valid pulses in lexicographic order ending at (6,7); hit_cnt=28.
